// File: rtl/tocador_notas.sv
// Note-sequence player: fetches one-hot notes from a per-song ROM, holds each for
// TICKS_NOTA cycles, then stays silent for TICKS_PAUSA cycles. Optional macro: TOCADOR_LOOP_EN.
module tocador_notas #(
  parameter int TICKS_NOTA  = 1000,
  parameter int TICKS_PAUSA = 250,
  parameter int CONT_W      = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [2:0] musica,
  input  logic [3:0] limite,
`ifdef TOCADOR_LOOP_EN
  input  logic       repetir,
`endif
  output logic [3:0] rom_address,
  output logic [2:0] rom_select,
  input  logic [6:0] rom_data,
  output logic [6:0] nota,
  output logic       nota_valida,
  output logic [3:0] indice,
  output logic       tocando,
  output logic       fim,
  output logic       erro_nota
);

  typedef enum logic [2:0] {IDLE, BUSCA, ESPERA, TOCA, PAUSA, FIM} state_t;

  localparam logic [CONT_W-1:0] FIM_NOTA  = CONT_W'(TICKS_NOTA - 1);
  localparam logic [CONT_W-1:0] FIM_PAUSA = (TICKS_PAUSA > 0) ? CONT_W'(TICKS_PAUSA - 1) : '0;

  state_t            state_reg, state_next;
  logic [3:0]        addr_reg, addr_next;
  logic [2:0]        sel_reg, sel_next;
  logic [3:0]        lim_reg, lim_next;
  logic [6:0]        nota_reg, nota_next;
  logic              valida_reg, valida_next;
  logic [3:0]        indice_reg, indice_next;
  logic              tocando_reg, tocando_next;
  logic              fim_reg, fim_next;
  logic              erro_reg, erro_next;
  logic [CONT_W-1:0] cont_reg, cont_next;
  logic              decide;
  logic              one_hot;

  assign one_hot = (rom_data != 7'd0) && ((rom_data & (rom_data - 7'd1)) == 7'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      sel_reg     <= '0;
      lim_reg     <= '0;
      nota_reg    <= '0;
      valida_reg  <= 1'b0;
      indice_reg  <= '0;
      tocando_reg <= 1'b0;
      fim_reg     <= 1'b0;
      erro_reg    <= 1'b0;
      cont_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      sel_reg     <= sel_next;
      lim_reg     <= lim_next;
      nota_reg    <= nota_next;
      valida_reg  <= valida_next;
      indice_reg  <= indice_next;
      tocando_reg <= tocando_next;
      fim_reg     <= fim_next;
      erro_reg    <= erro_next;
      cont_reg    <= cont_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    sel_next     = sel_reg;
    lim_next     = lim_reg;
    nota_next    = nota_reg;
    valida_next  = valida_reg;
    indice_next  = indice_reg;
    tocando_next = tocando_reg;
    fim_next     = 1'b0;
    erro_next    = erro_reg;
    cont_next    = cont_reg;
    decide       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iniciar) begin
          sel_next     = musica;
          lim_next     = limite;
          indice_next  = '0;
          addr_next    = '0;
          erro_next    = 1'b0;
          tocando_next = 1'b1;
          state_next   = BUSCA;
        end
      end
      BUSCA: state_next = ESPERA;
      ESPERA: begin
        // Malformed words are flagged but still played unchanged.
        nota_next   = rom_data;
        valida_next = 1'b1;
        cont_next   = '0;
        if (!one_hot) erro_next = 1'b1;
        state_next  = TOCA;
      end
      TOCA: begin
        if (cont_reg == FIM_NOTA) begin
          nota_next   = '0;
          valida_next = 1'b0;
          cont_next   = '0;
          if (TICKS_PAUSA == 0) decide = 1'b1;
          else                  state_next = PAUSA;
        end else begin
          cont_next = cont_reg + 1'b1;
        end
      end
      PAUSA: begin
        if (cont_reg == FIM_PAUSA) begin
          cont_next = '0;
          decide    = 1'b1;
        end else begin
          cont_next = cont_reg + 1'b1;
        end
      end
      FIM: begin
        tocando_next = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The next-note decision shares the edge that closes the note or its gap.
    if (decide) begin
      if (indice_reg == lim_reg) begin
`ifdef TOCADOR_LOOP_EN
        if (repetir) begin
          fim_next    = 1'b1;
          indice_next = '0;
          addr_next   = '0;
          state_next  = BUSCA;
        end else begin
          fim_next   = 1'b1;
          state_next = FIM;
        end
`else
        fim_next   = 1'b1;
        state_next = FIM;
`endif
      end else begin
        indice_next = indice_reg + 4'd1;
        addr_next   = indice_reg + 4'd1;
        state_next  = BUSCA;
      end
    end

    if (abortar && state_reg != IDLE) begin
      state_next   = IDLE;
      nota_next    = '0;
      valida_next  = 1'b0;
      tocando_next = 1'b0;
      fim_next     = 1'b0;
      cont_next    = '0;
    end
  end

  assign rom_address = addr_reg;
  assign rom_select  = sel_reg;
  assign nota        = nota_reg;
  assign nota_valida = valida_reg;
  assign indice      = indice_reg;
  assign tocando     = tocando_reg;
  assign fim         = fim_reg;
  assign erro_nota   = erro_reg;

endmodule
